pla_eval_sequencer: RTL and testbench



---
 rtl/pla_eval_pkg.sv | 25 ++
 rtl/pla_sat_counter.sv | 39 +++
 rtl/pla_eval_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pla_eval_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_eval_pkg.sv
// Shared definitions for the PLA evaluation sequencer.
//   - default configuration constants (input width, settle interval, counter width)
//   - sequencer state enum
//   - result record {vec, y} as presented on the result stream
package pla_eval_pkg;

  localparam int unsigned N_IN_DEFAULT          = 14;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;
  localparam int unsigned COUNT_W_DEFAULT       = 15;

  // Settle counter width; covers the legal settle range 1..15.
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

  typedef struct packed {
    logic [N_IN_DEFAULT-1:0] vec;
    logic                    y;
  } result_t;

endpackage

// File: rtl/pla_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset (count returns to 0)
//   clr    - synchronous clear; takes priority over inc
//   inc    - increment request; ignored once the count is all-ones
//   count  - current count value
module pla_sat_counter #(
  parameter int unsigned Width = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pla_eval_sequencer.sv
// Upstream driver and sampler for a single-output combinational PLA cube.
// Each accepted vector is registered onto the cube inputs x, held for SETTLE_CYCLES
// cycles, then y0 is sampled and {vector, y0} is offered on the result stream. Results
// accepted with y=1 are tallied in a saturating onset counter.
//
// Ports:
//   clk, rst_n           - clock (rising edge) and synchronous active-low reset
//   in_valid/in_ready    - vector input handshake; in_vec is the vector
//   x                    - registered drive to cube inputs x0..x(N_IN-1)
//   y0                   - cube output, combinational from x
//   out_valid/out_ready  - result handshake; out_vec/out_y are the result
//   onset_count          - accepted results with out_y=1 since reset, saturating
//   clr_count            - synchronous clear of onset_count (wins over increment)
//   sweep_start          - (optional) start an exhaustive sweep from IDLE
//   sweep_done           - (optional) one-cycle pulse after the last sweep result
//
// Optional feature macro: PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN adds an internal generator
// that feeds 0 .. 2^N_IN-1 in ascending order in place of in_vec.
//
// COUNT_W must be at least N_IN+1; SETTLE_CYCLES must lie in 1..15.
module pla_eval_sequencer
  import pla_eval_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int unsigned COUNT_W       = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_vec,
  output logic [N_IN-1:0]    x,
  input  logic               y0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_IN-1:0]    out_vec,
  output logic               out_y,
  output logic [COUNT_W-1:0] onset_count,
  input  logic               clr_count
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
  ,
  input  logic               sweep_start,
  output logic               sweep_done
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] SettleLoad = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_d, state_q;
  logic [N_IN-1:0]         x_d, x_q;
  logic                    y_d, y_q;
  logic [SETTLE_CNT_W-1:0] cnt_d, cnt_q;
  logic                    onset_inc;

`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
  logic            sweep_active_d, sweep_active_q;
  logic [N_IN-1:0] sweep_vec_d, sweep_vec_q;
  logic            sweep_done_d, sweep_done_q;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    onset_inc = 1'b0;
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
    sweep_active_d = sweep_active_q;
    sweep_vec_d    = sweep_vec_q;
    sweep_done_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
        // The generator owns the input side for the whole sweep.
        in_ready = !sweep_active_q;
        if (sweep_active_q) begin
          x_d     = sweep_vec_q;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else if (in_valid) begin
          x_d     = in_vec;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else if (sweep_start) begin
          sweep_active_d = 1'b1;
          sweep_vec_d    = '0;
        end
`else
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_vec;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
`endif
      end

      StSettle: begin
        if (cnt_q == '0) begin
          y_d     = y0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end
      end

      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          onset_inc = y_q;
          state_d   = StIdle;
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
          if (sweep_active_q) begin
            if (x_q == {N_IN{1'b1}}) begin
              sweep_active_d = 1'b0;
              sweep_done_d   = 1'b1;
            end else begin
              sweep_vec_d = sweep_vec_q + N_IN'(1);
            end
          end
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_active_q <= 1'b0;
      sweep_vec_q    <= '0;
      sweep_done_q   <= 1'b0;
    end else begin
      sweep_active_q <= sweep_active_d;
      sweep_vec_q    <= sweep_vec_d;
      sweep_done_q   <= sweep_done_d;
    end
  end

  assign sweep_done = sweep_done_q;
`endif

  // The cube drive and the reported vector are the same register: x is frozen
  // from accept until the result handshake.
  assign x       = x_q;
  assign out_vec = x_q;
  assign out_y   = y_q;

  pla_sat_counter #(
    .Width (COUNT_W)
  ) u_onset_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_count),
    .inc   (onset_inc),
    .count (onset_count)
  );

endmodule

// File: tb/tb_pla_eval_sequencer.sv
// Scoreboard bench for pla_eval_sequencer: the stimulus process pushes expected
// results at accept time; a negedge monitor pops and compares on each handshake and
// tracks the onset counter with a reference tally.
module tb_pla_eval_sequencer;
  import pla_eval_pkg::*;

  localparam int unsigned NIn    = 14;
  localparam int unsigned Settle = 2;
  localparam int unsigned CntW   = 15;
  localparam logic [NIn-1:0] Cube = 14'h3D25;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NIn-1:0]  in_vec = '0;
  logic [NIn-1:0]  x;
  logic            y0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NIn-1:0]  out_vec;
  logic            out_y;
  logic [CntW-1:0] onset_count;
  logic            clr_count = 1'b0;
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
  logic            sweep_start = 1'b0;
  logic            sweep_done;
`endif

  always #5 clk = ~clk;

  // Reference cube: a single full minterm, so y0 is 1 only for 0x3D25.
  function automatic logic ref_y(input logic [NIn-1:0] v);
    return v == Cube;
  endfunction

  assign y0 = ref_y(x);

  pla_eval_sequencer #(
    .N_IN          (NIn),
    .SETTLE_CYCLES (Settle),
    .COUNT_W       (CntW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .x           (x),
    .y0          (y0),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
    .out_y       (out_y),
    .onset_count (onset_count),
    .clr_count   (clr_count)
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
    ,
    .sweep_start (sweep_start),
    .sweep_done  (sweep_done)
`endif
  );

  result_t exp_q[$];
  int      cyc = 0;
  int      accept_cyc = 0;
  int      ready_mode = 0;  // 0: low, 1: high, 2: random
  int      tmo_cnt = 0;
  bit      in_sweep = 1'b0;
  bit      end_req = 1'b0;

  // Monitor-owned state.
  int      checks = 0;
  int      errors = 0;
  int      exp_cnt = 0;
  int      tmo_seen = 0;
  int      sweep_pulses = 0;
  bit      end_done = 1'b0;
  logic    last_rst = 1'b0;
  logic    prev_valid = 1'b0;
  logic    prev_hs = 1'b0;
  logic [NIn-1:0] prev_vec = '0;
  logic    prev_y = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic    hs;
    result_t e;
    hs = 1'b0;
    e  = '0;
    if (!last_rst) begin
      chk(x == '0, "reset x", int'(x), 0);
      chk(out_valid == 1'b0, "reset out_valid", int'(out_valid), 0);
      chk(in_ready == 1'b1, "reset in_ready", int'(in_ready), 1);
      chk(out_vec == '0, "reset out_vec", int'(out_vec), 0);
      chk(out_y == 1'b0, "reset out_y", int'(out_y), 0);
      chk(onset_count == '0, "reset onset_count", int'(onset_count), 0);
    end else begin
      chk(int'(onset_count) == exp_cnt, "onset_count", int'(onset_count), exp_cnt);
      if (out_valid) chk(in_ready == 1'b0, "in_ready during result", int'(in_ready), 0);
      if (prev_valid && !prev_hs) begin
        chk(out_valid == 1'b1, "out_valid held", int'(out_valid), 1);
        chk(out_vec == prev_vec, "out_vec stable", int'(out_vec), int'(prev_vec));
        chk(out_y == prev_y, "out_y stable", int'(out_y), int'(prev_y));
      end
      if (out_valid && !prev_valid && !in_sweep)
        chk(cyc == accept_cyc + Settle, "latency", cyc - accept_cyc, Settle);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected result", int'(out_vec), 0);
        end else begin
          e = exp_q.pop_front();
          chk(out_vec == e.vec, "out_vec", int'(out_vec), int'(e.vec));
          chk(out_y == e.y, "out_y", int'(out_y), int'(e.y));
        end
      end
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
      if (sweep_done) sweep_pulses++;
`endif
    end

    // Expected counter value after the coming edge.
    if (!rst_n) begin
      exp_cnt = 0;
      exp_q.delete();
    end else if (clr_count) begin
      exp_cnt = 0;
    end else if (hs && e.y && exp_cnt != CntMax) begin
      exp_cnt++;
    end

    if (tmo_cnt != tmo_seen) begin
      chk(1'b0, "wait timeout", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (end_req && !end_done) begin
      chk(exp_q.size() == 0, "results outstanding", exp_q.size(), 0);
`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
      chk(sweep_pulses == 1, "sweep_done pulses", sweep_pulses, 1);
`endif
      end_done = 1'b1;
    end

    last_rst   = rst_n;
    prev_valid = rst_n ? out_valid : 1'b0;
    prev_hs    = hs;
    prev_vec   = out_vec;
    prev_y     = out_y;
  end

  task automatic send(input logic [NIn-1:0] v);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (in_ready) begin
      accept_cyc = cyc + 1;
      exp_q.push_back('{vec: v, y: ref_y(v)});
    end else begin
      tmo_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) tmo_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
  endtask

  initial begin
    int n;
    logic [NIn-1:0] v;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // On-set then off-set vector.
    @(negedge clk) ready_mode = 1;
    send(Cube);
    drain(50);
    send(14'h3D27);
    drain(50);

    // Backpressure with a second vector waiting.
    @(negedge clk) ready_mode = 0;
    send(14'h0123);
    in_valid = 1'b1;
    in_vec   = 14'h2BCD;
    repeat (12) @(negedge clk);
    ready_mode = 1;
    send(14'h2BCD);
    drain(50);

    // Randomised traffic with random backpressure and occasional clears.
    @(negedge clk) ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) v = Cube;
      else v = NIn'($urandom);
      if ($urandom_range(0, 9) == 0) pulse_clr();
      send(v);
    end
    @(negedge clk) ready_mode = 1;
    drain(200);

    // Reset during SETTLE discards the pending result.
    send(Cube);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Build onset_count to 5, then clear in the same cycle as an on-set handshake.
    for (int i = 0; i < 5; i++) send(Cube);
    drain(100);
    @(negedge clk) ready_mode = 0;
    send(Cube);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) tmo_cnt++;
    ready_mode = 1;
    pulse_clr();
    drain(50);

`ifdef PLA_EVAL_SEQUENCER_EXHAUSTIVE_EN
    do_reset();
    @(negedge clk);
    in_sweep = 1'b1;
    for (int i = 0; i < (1 << NIn); i++) begin
      v = NIn'(i);
      exp_q.push_back('{vec: v, y: ref_y(v)});
    end
    @(posedge clk); #1;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    drain(80000);
    repeat (3) @(negedge clk);
    in_sweep = 1'b0;
`endif

    @(negedge clk);
    end_req = 1'b1;
    n = 0;
    while (!end_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!end_done) begin
      $display("FAIL monitor: end checks not reached");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
